// File: rtl/dm_pkg.sv
// Shared types for the memory stage: FSM states, the DM/WB latch layout and its
// bubble value, and the sizing of the access timeout counter.
package dm_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc;
    logic              halt_n;
    logic              err;
  } dmwb_t;

  // Empty latch slot; also the reset image (halt marker is active-low).
  localparam dmwb_t DMWB_BUBBLE = '{
    valid: 1'b0, read_data: '0, alu: '0, pc: '0, halt_n: 1'b1, err: 1'b0
  };

endpackage

// File: rtl/dm_mem_if.sv
// Request/acknowledge data-memory bus between the memory stage (master) and
// the data memory (slave).
interface dm_mem_if;

  logic                      req;
  logic                      wr;
  logic [dm_pkg::DATA_W-1:0] addr;
  logic [dm_pkg::DATA_W-1:0] wdata;
  logic [dm_pkg::DATA_W-1:0] rdata;
  logic                      ack;

  modport master (output req, wr, addr, wdata, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, output rdata, ack);

endinterface

// File: rtl/dmwb_latch.sv
// DM/WB pipeline register: one async-reset flop per field; a bubble load
// replaces the whole slot with the empty value.
module dmwb_latch
  import dm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ld,
  input  logic  bubble,
  input  dmwb_t d,
  output dmwb_t q
);

  dmwb_t nxt;
  logic              valid_p1;
  logic [DATA_W-1:0] read_data_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] pc_p1;
  logic              halt_n_p1;
  logic              err_p1;

  assign nxt = bubble ? DMWB_BUBBLE : d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_p1     <= DMWB_BUBBLE.valid;
      read_data_p1 <= DMWB_BUBBLE.read_data;
      alu_p1       <= DMWB_BUBBLE.alu;
      pc_p1        <= DMWB_BUBBLE.pc;
      halt_n_p1    <= DMWB_BUBBLE.halt_n;
      err_p1       <= DMWB_BUBBLE.err;
    end else if (ld) begin
      valid_p1     <= nxt.valid;
      read_data_p1 <= nxt.read_data;
      alu_p1       <= nxt.alu;
      pc_p1        <= nxt.pc;
      halt_n_p1    <= nxt.halt_n;
      err_p1       <= nxt.err;
    end
  end

  assign q = '{valid: valid_p1, read_data: read_data_p1, alu: alu_p1,
               pc: pc_p1, halt_n: halt_n_p1, err: err_p1};

endmodule

// File: rtl/dm_stage.sv
// Memory stage: issues loads/stores over a req/ack bus, stalls upstream while
// an access is in flight, and feeds the registered DM/WB latch.
module dm_stage
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] EXDM_ALU,
  input  logic [DATA_W-1:0] EXDM_RTData,
  input  logic [DATA_W-1:0] EXDM_PC,
  input  logic              EXDM_MemRead,
  input  logic              EXDM_MemWrt,
  input  logic              EXDM_HaltSig,
  input  logic              EXDM_err,
  dm_mem_if.master          mem,
  output logic              DM_stall,
  output logic              DMWB_valid,
  output logic [DATA_W-1:0] DMWB_ReadData,
  output logic [DATA_W-1:0] DMWB_ALU,
  output logic [DATA_W-1:0] DMWB_PC,
  output logic              DMWB_HaltSig,
  output logic              DMWB_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_p0, wdata_p0;
  logic              wr_p0;
  logic              acc, mis, conf;
  logic              capture, ld, bubble;
  dmwb_t             d, q;

  assign acc  = EXDM_MemRead ^ EXDM_MemWrt;
  assign mis  = acc & EXDM_ALU[0];
  assign conf = EXDM_MemRead & EXDM_MemWrt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    capture  = 1'b0;
    ld       = 1'b1;
    bubble   = 1'b0;
    DM_stall = 1'b0;
    mem.req  = 1'b0;
    d = '{valid: 1'b1, read_data: '0, alu: EXDM_ALU, pc: EXDM_PC,
          halt_n: EXDM_HaltSig, err: EXDM_err};
    case (state_q)
      IDLE: begin
        if (acc && !mis) begin
          capture  = 1'b1;
          DM_stall = 1'b1;
          bubble   = 1'b1;
          state_d  = ACCESS;
        end else begin
          d.err = EXDM_err | mis | conf;
          if (!EXDM_HaltSig) state_d = HALTED;
        end
      end
      ACCESS: begin
        mem.req  = 1'b1;
        DM_stall = !mem.ack;
        // An ack arriving in the last allowed cycle still completes cleanly.
        if (mem.ack) begin
          d.read_data = wr_p0 ? '0 : mem.rdata;
          state_d     = EXDM_HaltSig ? IDLE : HALTED;
        end else if (cnt_q == CNT_LAST) begin
          d.err   = 1'b1;
          state_d = EXDM_HaltSig ? IDLE : HALTED;
        end else begin
          bubble = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      HALTED: ld = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access capture: held for the whole ACCESS phase.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0  <= EXDM_ALU;
      wdata_p0 <= EXDM_RTData;
      wr_p0    <= EXDM_MemWrt;
    end
  end

  assign mem.wr    = mem.req & wr_p0;
  assign mem.addr  = mem.req ? addr_p0 : '0;
  assign mem.wdata = mem.req ? wdata_p0 : '0;

  dmwb_latch u_dmwb (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .bubble (bubble),
    .d      (d),
    .q      (q)
  );

  assign DMWB_valid    = q.valid;
  assign DMWB_ReadData = q.read_data;
  assign DMWB_ALU      = q.alu;
  assign DMWB_PC       = q.pc;
  assign DMWB_HaltSig  = q.halt_n;
  assign DMWB_err      = q.err;

endmodule

// File: doc/dm_stage.md
# dm_stage

Memory stage of the 5-stage pipeline. Consumes the EX/DM latch outputs, runs loads and stores against a variable-latency data memory through a request/acknowledge handshake, and stalls upstream while an access is in flight. It contains the DM/WB pipeline latch, so every output toward writeback is registered. Misaligned, conflicting or timed-out accesses become pipeline errors. A halting instruction freezes the stage.

## Interface
- TIMEOUT, 16: cycles in ACCESS without `mem_ack` before the access is aborted; legal range 2..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- EXDM_ALU  in  16  effective address, or ALU result for non-memory ops.
- EXDM_RTData  in  16  store data.
- EXDM_PC  in  16  PC of the instruction.
- EXDM_MemRead, EXDM_MemWrt  in  1  load / store request.
- EXDM_HaltSig  in  1  active-low halt marker.
- EXDM_err  in  1  error from earlier stages.
- mem_req  out  1  access request, held until acknowledged.
- mem_wr  out  1  1 = write.
- mem_addr, mem_wdata  out  16  held stable while `mem_req`=1.
- mem_rdata  in  16  read data, valid when `mem_ack`=1.
- mem_ack  in  1  access complete.
- DM_stall  out  1  upstream must hold the EX/DM latch this cycle.
- DMWB_valid  out  1  the DM/WB latch holds a real instruction.
- DMWB_ReadData, DMWB_ALU, DMWB_PC  out  16  latched results.
- DMWB_HaltSig  out  1  latched halt marker, active-low.
- DMWB_err  out  1  latched error.

## Operation
- **State machine.** States are IDLE, ACCESS and HALTED. All outputs reset to 0, except `DMWB_HaltSig`, which resets to 1. The state resets to IDLE and the timeout counter resets to 0.
- **Access condition.** Define `acc = MemRead ^ MemWrt`, `mis = acc & ALU[0]`, `conf = MemRead & MemWrt`.
- **IDLE, no access or a faulting access.** Applies when `!acc`, `mis` or `conf`.
  - The DM/WB latch loads ALU and PC, with `valid` = 1.
  - `err` = EXDM_err | mis | conf.
  - `ReadData` = 0 and `DM_stall` = 0.
  - No memory request is issued.
- **IDLE, clean access.** Applies when `acc & !mis`.
  - The stage captures the address, write data and write flag into internal registers.
  - `DM_stall` = 1 combinationally.
  - The DM/WB latch loads a bubble: `valid` = 0 and `err` = 0.
  - Next state is ACCESS and the counter is cleared.
- **ACCESS.**
  - `mem_req` = 1, with address, data and write flag driven from the captured registers.
  - `DM_stall` = !mem_ack.
  - On `mem_ack`:
    - The latch loads `ReadData` = mem_rdata for a load, or 0 for a store.
    - It also loads ALU, PC, halt and `valid` = 1.
    - `err` = EXDM_err.
    - Next state is IDLE.
  - Without `mem_ack`:
    - The counter increments and the latch loads bubbles.
    - When the counter reaches TIMEOUT−1, the next state is IDLE with `err` = 1 and `valid` = 1, and `mem_req` drops.
- **Halt.**
  - When an instruction with EXDM_HaltSig = 0 completes into the latch, the next state is HALTED.
  - In HALTED:
    - `DM_stall` = 0 and no requests are issued.
    - The latch holds its last contents; no further valid instructions enter.
    - The stage leaves HALTED only on reset.
- **Reset mid-access.** `mem_req` deasserts asynchronously. The memory must discard the partial access.

## Timing
- A non-memory instruction takes 1 cycle through the stage.
- A memory access takes 1 + N cycles, where N ≥ 1 is the ACCESS cycle in which `mem_ack` is sampled. The minimum is 2 cycles.
- `mem_ack` is ignored outside ACCESS.
- `mem_rdata` is sampled on the edge at which `mem_ack` = 1.
- `DM_stall` is combinational from state, the EXDM inputs and `mem_ack`. Upstream must not feed it back combinationally.
- Edge cases:
  - Ack in the timeout cycle: the ack wins, with no error.
  - Back-to-back accesses: a second access starts in the IDLE cycle immediately after the ack.

## Structure
- Shared package `dm_pkg`:
  - the state enum {IDLE, ACCESS, HALTED};
  - the bubble constant for the DM/WB latch fields;
  - the TIMEOUT width constant.
- Sub-module `dmwb_latch` is the DM/WB pipeline register. It has per-field async-reset flops, and a bubble input that forces `valid` = 0 and `err` = 0.
- The FSM and timeout counter stay in `dm_stage`.

## Test plan
- **Non-memory op:** ALU=0x1234, PC=0x0040, no Mem → next edge: DMWB_ALU=0x1234, valid=1, stall never 1.
- **Load with ack after 3 cycles:** ALU=0x0100, MemRead=1, rdata=0xBEEF → mem_req high 3 cycles, addr=0x0100, wr=0, stall high 3 cycles, then ReadData=0xBEEF, valid=1.
- **Store with immediate ack, followed by an ALU op:** ALU=0x0200, RTData=0x5A5A → mem_wr=1, wdata=0x5A5A, total 2 cycles; the next ALU op completes the following cycle.
- **Faulting accesses:** ALU=0x0101 with MemRead, and separately MemRead=MemWrt=1 → no mem_req, DMWB_err=1, 1-cycle latency.
- **Timeout:** no ack with TIMEOUT=16 → mem_req high exactly 16 cycles, then err=1, valid=1, state IDLE.
- **Halt, then reset mid-access:**
  - A halt on a store → HALTED after the ack, and subsequent loads issue no mem_req.
  - rst low during ACCESS → mem_req=0 immediately, all outputs at reset values.
